// File: rtl/tff_pkg.sv
// Shared types and helpers for the toggle-flip-flop counter.
package tff_pkg;

  localparam int unsigned MAX_WIDTH = 16;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_COUNT,
    OP_LOAD,
    OP_SET
  } op_e;

  // Out-of-range load values saturate to the top of the count range.
  function automatic logic [MAX_WIDTH-1:0] clamp_to_mod(input logic [MAX_WIDTH-1:0] v,
                                                        input int unsigned modulus);
    if (32'(v) < modulus) return v;
    return MAX_WIDTH'(modulus - 1);
  endfunction

endpackage

// File: rtl/tff_counter_if.sv
// Control and status bundle of the tff_counter.
interface tff_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             set;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             tc;
  logic             ovf;

  modport master (
    output en, up_dn, set, load, load_val,
    input  q, qbar, tc, ovf
  );

  modport slave (
    input  en, up_dn, set, load, load_val,
    output q, qbar, tc, ovf
  );
endinterface

// File: rtl/tff_bit.sv
// One T flip-flop with synchronous load and async active-low reset.
module tff_bit (
  input  logic clk,
  input  logic reset,
  input  logic t,
  input  logic ld,
  input  logic d,
  output logic q,
  output logic qbar
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  q <= 1'b0;
    else if (ld) q <= d;
    else if (t)  q <= ~q;
  end

  assign qbar = ~q;

endmodule

// File: rtl/tff_counter.sv
// Modulo up/down counter built from per-bit T cells; tc is combinational, ovf registered.
// Define TFF_COUNTER_SATURATE_EN to saturate at the range limits instead of wrapping.
module tff_counter
  import tff_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MOD   = 2 ** WIDTH
) (
  input logic           clk,
  input logic           reset,
  tff_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar_w;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] t;
  logic             ld;
  logic             at_max;
  logic             at_zero;
  logic             ovf_q;
  op_e              op;

  assign at_max  = (q == MAX_VAL);
  assign at_zero = (q == '0);

  // Priority select: set > load > count > hold
  always_comb begin
    op = OP_HOLD;
    if (bus.set)       op = OP_SET;
    else if (bus.load) op = OP_LOAD;
    else if (bus.en)   op = OP_COUNT;
  end

  always_comb begin
    q_next = q;
    case (op)
      OP_SET:  q_next = MAX_VAL;
      OP_LOAD: q_next = WIDTH'(clamp_to_mod(MAX_WIDTH'(bus.load_val), MOD));
      OP_COUNT: begin
        case (bus.up_dn)
          DIR_UP: begin
`ifdef TFF_COUNTER_SATURATE_EN
            q_next = at_max ? q : q + WIDTH'(1);
`else
            q_next = at_max ? '0 : q + WIDTH'(1);
`endif
          end
          DIR_DN: begin
`ifdef TFF_COUNTER_SATURATE_EN
            q_next = at_zero ? q : q - WIDTH'(1);
`else
            q_next = at_zero ? MAX_VAL : q - WIDTH'(1);
`endif
          end
          default: q_next = q;
        endcase
      end
      default: q_next = q;
    endcase
  end

  // Counting toggles only the bits that change; set/load use the direct load path
  always_comb begin
    t  = '0;
    ld = 1'b0;
    if (op == OP_COUNT)                    t  = q_next ^ q;
    if (op == OP_SET || op == OP_LOAD)     ld = 1'b1;
  end

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    tff_bit u_bit (
      .clk  (clk),
      .reset(reset),
      .t    (t[i]),
      .ld   (ld),
      .d    (q_next[i]),
      .q    (q[i]),
      .qbar (qbar_w[i])
    );
  end

  assign bus.tc = bus.en & ((bus.up_dn & at_max) | (~bus.up_dn & at_zero));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else begin
`ifdef TFF_COUNTER_SATURATE_EN
      ovf_q <= 1'b0;
`else
      ovf_q <= (op == OP_COUNT) & bus.tc;
`endif
    end
  end

  assign bus.q    = q;
  assign bus.qbar = qbar_w;
  assign bus.ovf  = ovf_q;

endmodule

// File: doc/tff_counter.md
Name: tff_counter

Overview:
- Parametrised synchronous up/down counter built from per-bit toggle flip-flops. It is the multi-bit successor of the single-bit T flip-flop with synchronous set.
- Adds programmable modulus, direction control, parallel load, terminal-count and overflow flags.
- Used as a divider/event counter in the flip-flop exercise set; drives downstream display/decoder logic.

Parameters:
- WIDTH, 4, counter width in bits (1..16)
- MOD, 2**WIDTH, count modulus; value range 0..MOD-1; legal range 2 <= MOD <= 2**WIDTH

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- en  in  1  count enable
- up_dn  in  1  count direction: 1 = up, 0 = down
- set  in  1  synchronous set: load MOD-1
- load  in  1  synchronous parallel load
- load_val  in  WIDTH  parallel load value
- q  out  WIDTH  count value
- qbar  out  WIDTH  bitwise complement of q, always
- tc  out  1  terminal count, combinational
- ovf  out  1  registered one-cycle wrap pulse

Behaviour:
- Reset (reset=0, async, immediate):
  - q = 0, qbar = all ones, ovf = 0.
  - Release is synchronous to clk; the first count occurs on the first rising edge with reset=1.
- Per-edge priority, highest first: set > load > en > hold.
  - set=1: q <= MOD-1, regardless of en/load.
  - load=1: q <= load_val if load_val < MOD, else MOD-1 (clamp).
  - en=1, up_dn=1: q <= (q==MOD-1) ? 0 : q+1.
  - en=1, up_dn=0: q <= (q==0) ? MOD-1 : q-1.
  - otherwise hold.
- Bit implementation: each bit is a T cell with toggle t[i] = q_next[i] ^ q[i]. All bits share clk; there is no ripple clocking.
- tc = en & ((up_dn & q==MOD-1) | (~up_dn & q==0)).
  - tc is asserted in the cycle before a wrap.
  - set and load do not gate tc.
- ovf is registered:
  - ovf <= 1 on the edge where a count wraps, i.e. tc=1 and neither set nor load asserted.
  - Otherwise ovf <= 0, so it is high for exactly one cycle after the wrap.
- Direction change mid-count takes effect on the next edge; no dead cycle.
- Inputs are assumed synchronous to clk; no internal synchronisers.
- Arithmetic is WIDTH bits, with wrap handled explicitly by MOD, not by natural overflow. With MOD = 2**WIDTH, behaviour equals natural wrap.
- Reset asserted mid-count forces q=0 and ovf=0 immediately, independent of clk.

Optional Feature:
- Macro: TFF_COUNTER_SATURATE_EN.
- Defined:
  - Counting saturates: up holds at MOD-1, down holds at 0.
  - tc still flags the limit value (with en).
  - ovf never asserts.
- Undefined: modulo wrap as above.
- set and load behave identically in both builds.

Decomposition:
- Package tff_pkg:
  - direction constants DIR_UP=1'b1, DIR_DN=1'b0
  - priority-select enum typedef {OP_HOLD, OP_COUNT, OP_LOAD, OP_SET}
  - function clamp_to_mod
- Sub-module tff_bit: one T flip-flop.
  - Ports: clk, reset (async active-low), t, ld, d, q, qbar.
  - Instantiated WIDTH times via generate.
- Top holds next-state/toggle logic, tc and ovf.

Test Plan (WIDTH=4, MOD=10 unless noted):
- Reset then en=1, up_dn=1 for 12 edges -> q: 1..9, 0, 1, 2. tc=1 while q=9. ovf=1 for one cycle when q=0.
- q=0, en=1, up_dn=0 -> q=9 on next edge, ovf pulse. tc=1 in the q=0 cycle only.
- load=1, load_val=13 -> q=9 (clamp). load_val=5 -> q=5, qbar=4'b1010. set=1 and load=1 together -> q=9.
- Count to q=6, drop reset for 3 ns between edges -> q=0 immediately, ovf=0. First count after release gives q=1.
- Build with TFF_COUNTER_SATURATE_EN, count up 12 edges -> q holds 9, tc=1, ovf never 1. Count down from 2 -> holds 0.
- WIDTH=3, MOD=8, count up 9 edges -> q wraps 7->0 naturally, ovf single pulse.
